// File: rtl/flatten_buffer.sv
// Flatten buffer: gathers a raster stream of signed elements into a parallel
// vector, pulses o_start once the vector is complete, and holds it until i_fc_done.
module flatten_buffer #(
    parameter int N_ELEM = 225,
    parameter int DATA_W = 22,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic                     i_sof,
    input  logic signed [DATA_W-1:0] i_data,
    output logic                     o_ready,
    output logic signed [DATA_W-1:0] o_flat_data [0:N_ELEM-1],
    output logic                     o_start,
    input  logic                     i_fc_done,
    output logic [CNT_W-1:0]         o_count,
    output logic                     o_drop_err,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Handshake: an element is accepted on any rising edge where i_valid=1 and
    // o_ready=1; i_valid=1 while o_ready=0 is discarded and flagged in o_drop_err.

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] wr_idx;
    logic             wr_en;
    logic             drop;
    logic             drop_err;

    assign wr_idx     = i_sof ? '0 : count;
    assign o_ready    = (state == COLLECT);
    assign o_start    = (state == START);
    assign o_count    = count;
    assign o_drop_err = drop_err;
    assign dbg_state  = state;

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        drop       = 1'b0;
        case (state)
            COLLECT: begin
                if (i_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx == CNT_W'(N_ELEM - 1)) begin
                        state_next = START;
                    end
                end
            end
            START: begin
                drop       = i_valid;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                drop = i_valid;
                if (i_fc_done) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= COLLECT;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            state <= state_next;
            if (drop) begin
                drop_err <= 1'b1;
            end
            if (wr_en) begin
                count <= CNT_W'(wr_idx + 1'b1);
            end else if (state == WAIT_DONE && i_fc_done) begin
                count <= '0;
            end
        end
    end

    // Decoded write per entry keeps out-of-range counter values harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ELEM; i++) begin
                o_flat_data[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < N_ELEM; i++) begin
                if (wr_idx == CNT_W'(i)) begin
                    o_flat_data[i] <= i_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_flatten_buffer.sv
// Directed bench for flatten_buffer: full frames, gapped frames, drops,
// mid-frame resync, asynchronous reset and back-to-back frames.
module tb_flatten_buffer;

    localparam int N  = 225;
    localparam int W  = 22;
    localparam int CW = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_valid = 1'b0;
    logic                i_sof = 1'b0;
    logic                i_fc_done = 1'b0;
    logic signed [W-1:0] i_data = '0;
    logic                o_ready;
    logic                o_start;
    logic                o_drop_err;
    logic signed [W-1:0] o_flat_data [0:N-1];
    logic [CW-1:0]       o_count;
    logic [1:0]          dbg_state;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int start_cnt = 0;
    int start_edge = 0;
    int dbl_start = 0;
    int first_edge = 0;
    logic prev_start = 1'b0;

    logic signed [W-1:0] exp_vec [0:N-1];
    int m_idx = 0;

    flatten_buffer #(.N_ELEM(N), .DATA_W(W), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .i_sof(i_sof),
        .i_data(i_data),
        .o_ready(o_ready),
        .o_flat_data(o_flat_data),
        .o_start(o_start),
        .i_fc_done(i_fc_done),
        .o_count(o_count),
        .o_drop_err(o_drop_err),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // start-pulse monitor; start_edge is the edge on which the FC layer samples o_start high
    always @(negedge clk) begin
        if (o_start === 1'b1) begin
            start_cnt  <= start_cnt + 1;
            start_edge <= edge_cnt + 1;
            if (prev_start === 1'b1) dbl_start <= dbl_start + 1;
        end
        prev_start <= o_start;
    end

    // driver tasks
    task automatic send(input logic signed [W-1:0] d, input bit sof);
        @(negedge clk);
        if (sof) begin
            first_edge = edge_cnt + 1;
            m_idx = 0;
        end
        i_valid = 1'b1;
        i_sof = sof;
        i_data = d;
        exp_vec[m_idx] = d;
        m_idx++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_sof = 1'b0;
        end
    endtask

    task automatic stream(input int base, input bit gaps);
        for (int k = 0; k < N; k++) begin
            send(W'(base + k), k == 0);
            if (gaps) idle(1);
        end
        idle(1);
    endtask

    task automatic wait_start(input int prev, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            if (start_cnt != prev) ok = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic release_fc();
        @(negedge clk);
        i_fc_done = 1'b1;
        @(negedge clk);
        i_fc_done = 1'b0;
    endtask

    function automatic int vec_errs();
        int n = 0;
        for (int k = 0; k < N; k++) begin
            if (o_flat_data[k] !== exp_vec[k]) n++;
        end
        return n;
    endfunction

    // scenarios
    task automatic test_reset();
        for (int k = 0; k < N; k++) exp_vec[k] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        total++; if (o_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        total++; if (o_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", o_start); end
        total++; if (o_drop_err !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b exp=0", o_drop_err); end
        total++; if (vec_errs() !== 0) begin bad++; $display("FAIL reset_vec bad_entries=%0d exp=0", vec_errs()); end
    endtask

    task automatic test_stream();
        int prev = start_cnt;
        bit ok;
        stream(-112, 1'b0);
        wait_start(prev, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL stream_start_seen got=%b exp=1", ok); end
        total++; if (start_edge - first_edge + 1 !== 226) begin bad++; $display("FAIL stream_latency got=%0d exp=226", start_edge - first_edge + 1); end
        total++; if (o_flat_data[0] !== -22'sd112) begin bad++; $display("FAIL stream_first got=%0d exp=-112", o_flat_data[0]); end
        total++; if (o_flat_data[224] !== 22'sd112) begin bad++; $display("FAIL stream_last got=%0d exp=112", o_flat_data[224]); end
        total++; if (vec_errs() !== 0) begin bad++; $display("FAIL stream_vec bad_entries=%0d exp=0", vec_errs()); end
        total++; if (o_count !== 8'd225) begin bad++; $display("FAIL stream_count got=%0d exp=225", o_count); end
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL stream_state got=%0d exp=2", dbg_state); end
        idle(10);
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL stream_hold_ready got=%b exp=0", o_ready); end
        total++; if (start_cnt !== prev + 1) begin bad++; $display("FAIL stream_pulses got=%0d exp=%0d", start_cnt, prev + 1); end
        release_fc();
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL stream_release_ready got=%b exp=1", o_ready); end
        total++; if (o_count !== 8'd0) begin bad++; $display("FAIL stream_release_count got=%0d exp=0", o_count); end
    endtask

    task automatic test_gaps();
        int prev = start_cnt;
        bit ok;
        stream(-112, 1'b1);
        wait_start(prev, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL gaps_start_seen got=%b exp=1", ok); end
        total++; if (start_edge - first_edge + 1 !== 450) begin bad++; $display("FAIL gaps_latency got=%0d exp=450", start_edge - first_edge + 1); end
        total++; if (vec_errs() !== 0) begin bad++; $display("FAIL gaps_vec bad_entries=%0d exp=0", vec_errs()); end
        total++; if (o_drop_err !== 1'b0) begin bad++; $display("FAIL gaps_drop got=%b exp=0", o_drop_err); end
    endtask

    task automatic test_drop();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data = 22'h3FFFFF;
        end
        idle(2);
        total++; if (vec_errs() !== 0) begin bad++; $display("FAIL drop_vec bad_entries=%0d exp=0", vec_errs()); end
        total++; if (o_drop_err !== 1'b1) begin bad++; $display("FAIL drop_flag got=%b exp=1", o_drop_err); end
        total++; if (o_count !== 8'd225) begin bad++; $display("FAIL drop_count got=%0d exp=225", o_count); end
        release_fc();
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL drop_release_ready got=%b exp=1", o_ready); end
        total++; if (o_count !== 8'd0) begin bad++; $display("FAIL drop_release_count got=%0d exp=0", o_count); end
        idle(3);
        total++; if (o_drop_err !== 1'b1) begin bad++; $display("FAIL drop_sticky got=%b exp=1", o_drop_err); end
    endtask

    task automatic test_resync();
        int prev;
        bit ok;
        for (int k = 0; k < 100; k++) send(W'(1000 + k), k == 0);
        prev = start_cnt;
        send(22'sd7, 1'b1);
        for (int j = 1; j < N - 1; j++) send(W'(2000 + j), 1'b0);
        idle(3);
        total++; if (start_cnt !== prev) begin bad++; $display("FAIL resync_early_start got=%0d exp=%0d", start_cnt, prev); end
        total++; if (o_count !== 8'd224) begin bad++; $display("FAIL resync_count got=%0d exp=224", o_count); end
        send(W'(2000 + N - 1), 1'b0);
        idle(1);
        wait_start(prev, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL resync_start_seen got=%b exp=1", ok); end
        total++; if (start_edge - first_edge + 1 !== 229) begin bad++; $display("FAIL resync_latency got=%0d exp=229", start_edge - first_edge + 1); end
        total++; if (o_flat_data[0] !== 22'sd7) begin bad++; $display("FAIL resync_first got=%0d exp=7", o_flat_data[0]); end
        total++; if (vec_errs() !== 0) begin bad++; $display("FAIL resync_vec bad_entries=%0d exp=0", vec_errs()); end
        release_fc();
    endtask

    task automatic test_reset_mid();
        int prev = start_cnt;
        bit ok;
        for (int k = 0; k < 150; k++) send(W'(300 + k), k == 0);
        #2 rst = 1'b1;
        i_valid = 1'b0;
        i_sof = 1'b0;
        #1;
        total++; if (o_count !== 8'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", o_count); end
        total++; if (o_flat_data[0] !== 22'sd0) begin bad++; $display("FAIL rstmid_first got=%0d exp=0", o_flat_data[0]); end
        total++; if (o_flat_data[148] !== 22'sd0) begin bad++; $display("FAIL rstmid_entry148 got=%0d exp=0", o_flat_data[148]); end
        total++; if (o_drop_err !== 1'b0) begin bad++; $display("FAIL rstmid_drop got=%b exp=0", o_drop_err); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", o_ready); end
        for (int k = 0; k < N; k++) exp_vec[k] = '0;
        m_idx = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(250);
        total++; if (start_cnt !== prev) begin bad++; $display("FAIL rstmid_no_start got=%0d exp=%0d", start_cnt, prev); end
        stream(-50, 1'b0);
        wait_start(prev, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_refill_start got=%b exp=1", ok); end
        total++; if (vec_errs() !== 0) begin bad++; $display("FAIL rstmid_refill_vec bad_entries=%0d exp=0", vec_errs()); end
        total++; if (start_edge - first_edge + 1 !== 226) begin bad++; $display("FAIL rstmid_latency got=%0d exp=226", start_edge - first_edge + 1); end
        release_fc();
    endtask

    task automatic test_back_to_back();
        int prev = start_cnt;
        bit ok;
        stream(500, 1'b0);
        wait_start(prev, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_first_start got=%b exp=1", ok); end
        total++; if (vec_errs() !== 0) begin bad++; $display("FAIL b2b_first_vec bad_entries=%0d exp=0", vec_errs()); end
        idle(5);
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL b2b_wait_ready got=%b exp=0", o_ready); end
        release_fc();
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept_ready got=%b exp=1", o_ready); end
        stream(-700, 1'b0);
        wait_start(prev + 1, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_second_start got=%b exp=1", ok); end
        total++; if (o_flat_data[5] !== -22'sd695) begin bad++; $display("FAIL b2b_second_entry5 got=%0d exp=-695", o_flat_data[5]); end
        total++; if (vec_errs() !== 0) begin bad++; $display("FAIL b2b_second_vec bad_entries=%0d exp=0", vec_errs()); end
        release_fc();
        idle(3);
        total++; if (start_cnt !== prev + 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=%0d", start_cnt, prev + 2); end
        total++; if (o_drop_err !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b exp=0", o_drop_err); end
        total++; if (dbl_start !== 0) begin bad++; $display("FAIL start_double got=%0d exp=0", dbl_start); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_drop();
        test_resync();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
